// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: access FSM states and RISC-V funct3 size/sign codes.
package mem_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE} state_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;
endpackage

// File: rtl/mem_size_unit.sv
// mem_size_unit: store byte-lane merge and load sign/zero extension.
module mem_size_unit
  import mem_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [63:0] store_data,
  input  logic [63:0] rdata,
  output logic [63:0] wdata,
  output logic [63:0] ldata
);
  always_comb begin
    wdata = funct3 == F3_B ? {rdata[63:8], store_data[7:0]} :
            funct3 == F3_H ? {rdata[63:16], store_data[15:0]} :
            funct3 == F3_W ? {rdata[63:32], store_data[31:0]} : store_data;
    ldata = funct3 == F3_B  ? {{56{rdata[7]}}, rdata[7:0]} :
            funct3 == F3_H  ? {{48{rdata[15]}}, rdata[15:0]} :
            funct3 == F3_W  ? {{32{rdata[31]}}, rdata[31:0]} :
            funct3 == F3_BU ? {56'd0, rdata[7:0]} :
            funct3 == F3_HU ? {48'd0, rdata[15:0]} :
            funct3 == F3_WU ? {32'd0, rdata[31:0]} : rdata;
  end
endmodule

// File: rtl/mem_store_ctrl.sv
// mem_store_ctrl: load/store sequencer with read-modify-write for partial stores.
module mem_store_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [63:0] addr,
  input  logic [63:0] store_data,
  input  logic [63:0] mem_rdata,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  output logic [63:0] load_data,
  output logic        busy,
  output logic        done
);
  state_t      state;
  logic [3:0]  cnt;
  logic        st_q;
  logic [2:0]  f3_q;
  logic [63:0] sd_q;
  logic        accept;
  logic        full;
  logic [2:0]  f3_n;
  logic [63:0] sd_n;
  logic [63:0] wd;
  logic [63:0] ld;
  always_comb begin
    accept = state == S_IDLE && start;
    full   = funct3 == F3_D || funct3[2];
    f3_n   = accept ? funct3 : f3_q;
    sd_n   = accept ? store_data : sd_q;
    mem_re = state == S_READ;
    mem_we = state == S_WRITE;
    busy   = state != S_IDLE;
    done   = state == S_DONE;
  end
  // Merge/extend sees the live inputs on the accept edge and mem_rdata on the last WAIT edge.
  mem_size_unit u_size (
    .funct3    (f3_n),
    .store_data(sd_n),
    .rdata     (mem_rdata),
    .wdata     (wd),
    .ldata     (ld)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      st_q      <= 1'b0;
      f3_q      <= '0;
      sd_q      <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      load_data <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          st_q     <= is_store;
          f3_q     <= funct3;
          sd_q     <= store_data;
          mem_addr <= addr;
          if (is_store && full) begin
            state     <= S_WRITE;
            mem_wdata <= wd;
          end else state <= S_READ;
        end
        S_READ: begin
          state <= S_WAIT;
          cnt   <= 4'(MEM_LAT - 1);
        end
        S_WAIT: if (cnt == '0) begin
          if (st_q) begin
            state     <= S_WRITE;
            mem_wdata <= wd;
          end else begin
            state     <= S_DONE;
            load_data <= ld;
          end
        end else cnt <= cnt - 4'd1;
        S_WRITE: state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_store_ctrl.sv
// tb_mem_store_ctrl: directed scoreboard bench driving MEM_LAT=1 and MEM_LAT=3 instances in lockstep.
module tb_mem_store_ctrl;
  logic        clk = 0, reset = 0, start = 0, is_store = 0;
  logic [2:0]  funct3 = '0;
  logic [63:0] addr = '0, store_data = '0, mem_rdata = '0;
  logic [1:0]  re, we, bsy, dn;
  logic [63:0] ma[2], mw[2], ld[2];
  logic [63:0] sbq0[$], sbq1[$];
  logic [63:0] last_ld[2];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  mem_store_ctrl #(.MEM_LAT(1)) u1 (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .store_data(store_data), .mem_rdata(mem_rdata),
    .mem_addr(ma[0]), .mem_wdata(mw[0]), .mem_re(re[0]), .mem_we(we[0]),
    .load_data(ld[0]), .busy(bsy[0]), .done(dn[0]));
  mem_store_ctrl #(.MEM_LAT(3)) u3 (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .store_data(store_data), .mem_rdata(mem_rdata),
    .mem_addr(ma[1]), .mem_wdata(mw[1]), .mem_re(re[1]), .mem_we(we[1]),
    .load_data(ld[1]), .busy(bsy[1]), .done(dn[1]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] merge_m(input logic [2:0] f, input logic [63:0] s, input logic [63:0] r);
    logic [63:0] m;
    case (f)
      3'b000:  m = 64'hFF;
      3'b001:  m = 64'hFFFF;
      3'b010:  m = 64'hFFFF_FFFF;
      default: m = '1;
    endcase
    return (s & m) | (r & ~m);
  endfunction

  function automatic logic [63:0] ext_m(input logic [2:0] f, input logic [63:0] r);
    int w;
    logic [63:0] m, v;
    w = f[1:0] == 2'd0 ? 8 : f[1:0] == 2'd1 ? 16 : f[1:0] == 2'd2 ? 32 : 64;
    m = w == 64 ? '1 : (64'd1 << w) - 64'd1;
    v = r & m;
    if (!f[2] && w < 64 && r[w-1]) v = v | ~m;
    return v;
  endfunction

  task automatic chk_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_re%0d", tag, i), re[i], 0);
      chk($sformatf("%s_we%0d", tag, i), we[i], 0);
      chk($sformatf("%s_busy%0d", tag, i), bsy[i], 0);
      chk($sformatf("%s_done%0d", tag, i), dn[i], 0);
      chk($sformatf("%s_addr%0d", tag, i), ma[i], 0);
      chk($sformatf("%s_wdata%0d", tag, i), mw[i], 0);
      chk($sformatf("%s_ld%0d", tag, i), ld[i], 0);
    end
  endtask

  task automatic access(input logic st, input logic [2:0] f, input logic [63:0] a,
                        input logic [63:0] s, input logic [63:0] r);
    int dc[2], wc[2], rc[2];
    logic full;
    logic [63:0] e;
    full = st && (f == 3'b011 || f[2]);
    for (int i = 0; i < 2; i++) begin
      dc[i] = full ? 2 : st ? 3 + (i ? 3 : 1) : 2 + (i ? 3 : 1);
      wc[i] = st ? dc[i] - 1 : -1;
      rc[i] = full ? -1 : 1;
    end
    e = st ? merge_m(f, s, r) : ext_m(f, r);
    sbq0.push_back(e);
    sbq1.push_back(e);
    start = 1; is_store = st; funct3 = f; addr = a; store_data = s; mem_rdata = r;
    @(posedge clk); #1;
    start = 0; is_store = ~st; funct3 = ~f; addr = ~a; store_data = ~s;
    for (int k = 1; k <= dc[1] + 1; k++) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("re%0d_k%0d", i, k), re[i], k == rc[i]);
        chk($sformatf("we%0d_k%0d", i, k), we[i], k == wc[i]);
        chk($sformatf("done%0d_k%0d", i, k), dn[i], k == dc[i]);
        chk($sformatf("busy%0d_k%0d", i, k), bsy[i], k <= dc[i]);
        if (k == rc[i] || k == wc[i]) chk($sformatf("addr%0d_k%0d", i, k), ma[i], a);
        if (k == wc[i]) begin
          e = i ? sbq1.pop_front() : sbq0.pop_front();
          chk($sformatf("wdata%0d", i), mw[i], e);
        end
        if (k == dc[i]) begin
          if (!st) begin
            e = i ? sbq1.pop_front() : sbq0.pop_front();
            last_ld[i] = e;
          end
          chk($sformatf("load%0d", i), ld[i], last_ld[i]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    int nd[2], ni[2];
    last_ld[0] = '0;
    last_ld[1] = '0;
    #2;
    chk_zero("rst");
    repeat (2) @(posedge clk);
    #1 reset = 1;
    access(1, 3'b011, 64'h40, 64'h1122334455667788, 64'h5555_5555_5555_5555);
    access(1, 3'b000, 64'h48, 64'hAB, '1);
    access(0, 3'b001, 64'h50, '0, 64'h8001);
    access(0, 3'b101, 64'h52, '0, 64'h8001);
    access(1, 3'b010, 64'h60, 64'hDEADBEEF, 64'h0123456789ABCDEF);
    access(0, 3'b000, 64'h70, '0, 64'h1234_5678_9ABC_DE80);
    access(0, 3'b100, 64'h71, '0, 64'h1234_5678_9ABC_DEF0);
    access(0, 3'b110, 64'h78, '0, 64'h1234_5678_9ABC_DEF0);
    access(0, 3'b010, 64'h7C, '0, 64'h1234_5678_9ABC_DEF0);
    access(0, 3'b011, 64'h80, '0, 64'hFEDC_BA98_7654_3210);
    access(1, 3'b001, 64'h88, 64'h5A5A_CAFE, 64'h1111_1111_1111_1111);
    access(0, 3'b111, 64'h90, '0, 64'h8000_0000_0000_0001);
    // Back-to-back with start held high: one IDLE cycle between accesses.
    nd = '{0, 0};
    ni = '{0, 0};
    start = 1; is_store = 0; funct3 = 3'b010; addr = 64'hA0; mem_rdata = 64'h0000_0000_8000_0001;
    for (int n = 0; n < 12; n++) begin
      logic [1:0] pd;
      pd = dn;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (dn[i]) nd[i]++;
        if (!bsy[i]) ni[i]++;
        if (n > 0) chk($sformatf("b2b_pulse%0d_n%0d", i, n), pd[i] & dn[i], 0);
      end
    end
    start = 0;
    chk("b2b_done0", 64'(nd[0]), 3);
    chk("b2b_done1", 64'(nd[1]), 2);
    chk("b2b_idle0", 64'(ni[0]), 3);
    chk("b2b_idle1", 64'(ni[1]), 2);
    for (int n = 0; n < 10 && bsy != 2'b00; n++) begin
      @(posedge clk); #1;
    end
    chk("b2b_drain", bsy, 0);
    for (int i = 0; i < 2; i++) begin
      last_ld[i] = 64'hFFFF_FFFF_8000_0001;
      chk($sformatf("b2b_ld%0d", i), ld[i], last_ld[i]);
    end
    // Reset during WAIT of a partial store aborts without a write.
    start = 1; is_store = 1; funct3 = 3'b000; addr = 64'hB0; store_data = 64'hAB; mem_rdata = '1;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    reset = 0;
    #1;
    chk_zero("midrst");
    last_ld[0] = '0;
    last_ld[1] = '0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      chk($sformatf("midrst_we_n%0d", n), we, 0);
    end
    reset = 1;
    access(1, 3'b011, 64'hC0, 64'h0F0F_0F0F_0F0F_0F0F, '0);
    access(0, 3'b000, 64'hC8, '0, 64'h7F);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
